// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and parameter defaults.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH          = 5;
    localparam int DEF_TICK_DIV       = 1;
    localparam bit DEF_AUTO_RELOAD_EN = 1'b0;

    // Wide enough for the largest supported divide ratio (255).
    localparam int PRESCALE_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the tick strobe by TICK_DIV; pulse marks the tick that completes a full period.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock_out,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic pulse
);

    localparam logic [PRESCALE_W-1:0] TERMINAL = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] phase;
    logic                  at_terminal;
    logic                  advance;

    assign at_terminal = (phase == TERMINAL);
    assign advance     = enable && tick;
    assign pulse       = advance && at_terminal;

    // Phase is only touched by clear or an enabled tick, so it holds through PAUSE.
    always_ff @(posedge clock_out or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (advance) begin
            phase <= at_terminal ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer with pause/resume, restart and optional auto-reload on expiry.
//   state    | meaning
//   ST_IDLE  | loaded, waiting for start
//   ST_RUN   | counting down on prescaled ticks
//   ST_PAUSE | frozen, count and prescaler phase held
//   ST_DONE  | expired, count held at 0
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter bit AUTO_RELOAD_EN = DEF_AUTO_RELOAD_EN
) (
    input  logic             clock_out,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             restart,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             reload_active;
    logic             at_zero;
    logic             presc_enable;
    logic             presc_pulse;

    assign reload_active = AUTO_RELOAD_EN && auto_reload;
    assign at_zero       = (count == '0);
    // Ticks only count in RUN when no command or pending expiry claims the cycle.
    assign presc_enable  = (state == ST_RUN) && !restart && !pause && !at_zero;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock_out (clock_out),
        .reset_n   (reset_n),
        .enable    (presc_enable),
        .clear     (restart),
        .tick      (tick),
        .pulse     (presc_pulse)
    );

    always_ff @(posedge clock_out or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        if (restart) begin
            state_nxt = ST_IDLE;
            count_nxt = load_val;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSE;
                    end else if (at_zero) begin
                        // Count reached 0 on the previous edge (or RUN was entered at 0).
                        done_nxt = 1'b1;
                        if (reload_active) begin
                            count_nxt = load_val;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else if (presc_pulse) begin
                        count_nxt = count - 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                        count_nxt = load_val;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign running = (state == ST_RUN);
    assign paused  = (state == ST_PAUSE);
    assign expired = (state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: instance A (TICK_DIV=1, auto-reload enabled) and instance B
// (TICK_DIV=3, single-shot) share one stimulus stream.
module tb_countdown_timer;

    localparam int WIDTH = 5;

    logic             clock_out;
    logic             reset_n;
    logic             tick;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             restart;
    logic             auto_reload;

    logic [WIDTH-1:0] a_count;
    logic             a_running, a_paused, a_expired, a_done;
    logic [WIDTH-1:0] b_count;
    logic             b_running, b_paused, b_expired, b_done;

    int n_vec;
    int n_err;
    int a_pulses;
    int b_pulses;

    countdown_timer #(.WIDTH(WIDTH), .TICK_DIV(1), .AUTO_RELOAD_EN(1'b1)) dut_a (
        .clock_out   (clock_out),
        .reset_n     (reset_n),
        .tick        (tick),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .restart     (restart),
        .auto_reload (auto_reload),
        .count       (a_count),
        .running     (a_running),
        .paused      (a_paused),
        .expired     (a_expired),
        .done        (a_done)
    );

    countdown_timer #(.WIDTH(WIDTH), .TICK_DIV(3), .AUTO_RELOAD_EN(1'b0)) dut_b (
        .clock_out   (clock_out),
        .reset_n     (reset_n),
        .tick        (tick),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .restart     (restart),
        .auto_reload (auto_reload),
        .count       (b_count),
        .running     (b_running),
        .paused      (b_paused),
        .expired     (b_expired),
        .done        (b_done)
    );

    initial clock_out = 1'b0;
    always #5 clock_out = ~clock_out;

    always @(negedge clock_out) begin
        if (a_done === 1'b1) a_pulses++;
        if (b_done === 1'b1) b_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock_out);
        #1;
    endtask

    initial begin
        int exp_b034 [6];
        int exp_a036 [9];
        exp_b034 = '{2, 2, 1, 1, 1, 0};
        exp_a036 = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        n_vec = 0; n_err = 0; a_pulses = 0; b_pulses = 0;
        reset_n = 1'b0; tick = 1'b0; load_val = '0; start = 1'b0;
        pause = 1'b0; restart = 1'b0; auto_reload = 1'b0;

        // reset state
        repeat (3) cyc();
        check("rst_a_count", a_count, 0);
        check("rst_a_flags", {a_running, a_paused, a_expired, a_done}, 4'b0000);
        check("rst_b_count", b_count, 0);
        reset_n = 1'b1;
        cyc();

        // basic countdown 5 -> 0
        load_val = 5; a_pulses = 0;
        restart = 1'b1; cyc(); restart = 1'b0;
        check("t1_idle_count", a_count, 5);
        check("t1_idle_running", a_running, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check("t1_run", a_running, 1);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            check("t1_count", a_count, 4 - i);
        end
        check("t1_b_div3_count", b_count, 4);
        check("t1_done_late", a_done, 0);
        cyc();
        check("t1_done_pulse", a_done, 1);
        check("t1_expired", a_expired, 1);
        check("t1_running_off", a_running, 0);
        cyc();
        check("t1_done_clear", a_done, 0);
        check("t1_hold_zero", a_count, 0);
        check("t1_pulses", a_pulses, 1);

        // prescaler divide by 3
        load_val = 2; b_pulses = 0;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("t2_start_count", b_count, 2);
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            check("t2_count", b_count, exp_b034[i]);
        end
        cyc();
        check("t2_done", b_done, 1);
        check("t2_expired", b_expired, 1);
        cyc();
        check("t2_pulses", b_pulses, 1);

        // pause / resume
        load_val = 4;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
        end
        check("t3_pre_pause", a_count, 2);
        pause = 1'b1; cyc(); pause = 1'b0;
        check("t3_paused", {a_running, a_paused}, 2'b01);
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            check("t3_hold", a_count, 2);
        end
        check("t3_b_hold", b_count, 4);
        start = 1'b1; cyc(); start = 1'b0;
        check("t3_resumed", {a_running, a_paused}, 2'b10);
        tick = 1'b1; cyc(); tick = 1'b0;
        check("t3_count1", a_count, 1);
        check("t3_b_phase_kept", b_count, 3);
        tick = 1'b1; cyc(); tick = 1'b0;
        check("t3_count0", a_count, 0);
        cyc();
        check("t3_expired", {a_expired, a_done, a_paused}, 3'b110);

        // auto-reload
        load_val = 3; auto_reload = 1'b1; a_pulses = 0;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("t4_start", a_count, 3);
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            cyc();
            check("t4_count", a_count, exp_a036[i]);
            check("t4_running", a_running, 1);
        end
        check("t4_pulses", a_pulses, 3);
        check("t4_b_single_shot", {b_expired, b_running}, 2'b10);
        check("t4_b_count", b_count, 0);

        // auto-reload with load_val 0
        load_val = 0; a_pulses = 0;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t5_done_each", {a_done, a_running}, 2'b11);
        end
        check("t5_pulses", a_pulses, 4);

        // command priority and tick suppression
        auto_reload = 1'b0; load_val = 7;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; pause = 1'b1; start = 1'b1; cyc();
        tick = 1'b0; pause = 1'b0; start = 1'b0;
        check("t6_paused", a_paused, 1);
        check("t6_count7", a_count, 7);
        start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
        check("t6_resume_notick", {a_running, a_count}, {1'b1, 5'd7});
        tick = 1'b1; cyc(); tick = 1'b0;
        check("t6_count6", a_count, 6);
        load_val = 12;
        restart = 1'b1; start = 1'b1; cyc(); restart = 1'b0; start = 1'b0;
        check("t6_restart_wins", {a_running, a_paused, a_expired}, 3'b000);
        check("t6_reload", a_count, 12);

        // async reset mid-run
        load_val = 9;
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("t7_run9", {a_running, a_count}, {1'b1, 5'd9});
        #2 reset_n = 1'b0;
        #1;
        check("t7_async_count", a_count, 0);
        check("t7_async_flags", {a_running, a_paused, a_expired, a_done}, 4'b0000);
        #1 reset_n = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        check("t7_run0", {a_running, a_count}, {1'b1, 5'd0});
        check("t7_no_done_yet", a_done, 0);
        cyc();
        check("t7_done", {a_done, a_expired}, 2'b11);
        check("t7_b_done", {b_done, b_expired}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
